// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared width and lane-placement helpers for bus packer/unpacker
// Purpose: constants and helper functions shared by the bus joiner/splitter family.
// Ports: none (package).
package bus_pkg;

  // Width of a beat-count field that must represent 0..ratio inclusive.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  // Bit position of the LSB of lane k inside an in_w*ratio word.
  // msb_first=1 puts beat 0 in the top lane, msb_first=0 puts it in lane 0.
  function automatic int lane_lsb(input int k, input int in_w, input int ratio,
                                  input bit msb_first);
    return msb_first ? (ratio - 1 - k) * in_w : k * in_w;
  endfunction

endpackage

// File: rtl/bus_packer_if.sv
// rtl/bus_packer_if.sv - narrow-in / wide-out stream interface for bus_packer
// Purpose: bundles the input beat stream and packed output word stream.
// Signals:
//   in_data/in_valid/in_last/in_ready      narrow beat stream into the packer
//   out_data/out_valid/out_count/out_last/out_ready  packed word stream out
// Modports: master = stream source/sink around the packer, slave = the packer.
interface bus_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  import bus_pkg::*;

  localparam int OUT_W = IN_W * RATIO;
  localparam int CNT_W = cnt_width(RATIO);

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic             out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_count, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_count, out_last
  );

endinterface

// File: rtl/bus_out_reg.sv
// rtl/bus_out_reg.sv - valid/ready holding register for a data+count+last word
// Purpose: one-deep output register; loads a word, holds it stable under
//          backpressure and drains on out_valid && out_ready.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   load, load_data/count/last         write a new word (only when can_load)
//   can_load                           register is empty or draining this cycle
//   out_valid/out_data/out_count/out_last, out_ready   output handshake
module bus_out_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              load_last,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_q,  last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    last_d  = last_q;
    // A load in the same cycle as a drain replaces the word without a bubble.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      count_d = load_count;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_last  = last_q;

endmodule

// File: rtl/bus_packer.sv
// rtl/bus_packer.sv - joins RATIO narrow beats into one wide word
// Purpose: accumulates IN_W-bit beats into an IN_W*RATIO-bit word; a word
//          closes after RATIO beats or on in_last (partial word, unused lanes 0).
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; discards any partial word
//   bus      bus_packer_if.slave: in_* beat stream, out_* packed word stream
module bus_packer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_packer_if.slave  bus
);
  import bus_pkg::*;

  localparam int OUT_W  = IN_W * RATIO;
  localparam int CNT_W  = cnt_width(RATIO);
  localparam int LANE_W = $clog2(RATIO);

  logic [LANE_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [OUT_W-1:0]  merged;
  logic [CNT_W-1:0]  word_count;
  logic              in_ready;
  logic              beat_fire;
  logic              closing;
  int                lsb;

  assign beat_fire  = bus.in_valid && in_ready;
  assign closing    = beat_fire && ((cnt_q == LANE_W'(RATIO - 1)) || bus.in_last);
  assign word_count = CNT_W'(cnt_q) + CNT_W'(1);
  assign bus.in_ready = in_ready;

  // Accumulator with the current beat dropped into its lane; this is both
  // the next accumulator value and, on a closing beat, the outgoing word.
  always_comb begin
    lsb    = lane_lsb(int'(cnt_q), IN_W, RATIO, MSB_FIRST);
    merged = acc_q;
    merged[lsb +: IN_W] = bus.in_data;
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (beat_fire) begin
      if (closing) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + LANE_W'(1);
        acc_d = merged;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  bus_out_reg #(
    .DATA_W (OUT_W),
    .CNT_W  (CNT_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (closing),
    .load_data  (merged),
    .load_count (word_count),
    .load_last  (bus.in_last),
    .out_ready  (bus.out_ready),
    .can_load   (in_ready),
    .out_valid  (bus.out_valid),
    .out_data   (bus.out_data),
    .out_count  (bus.out_count),
    .out_last   (bus.out_last)
  );

endmodule
